// File: rtl/sparsity_encoder.sv
// Dense-to-sparse line encoder: emits one zero/nonzero flag per element, streams
// nonzero values with their in-line index, and reports a nonzero count per line.
module sparsity_encoder #(
  parameter int DATA_WIDTH  = 8,
  parameter int LINE_LEN    = 16,
  parameter int IDX_WIDTH   = 4,
  parameter int CNT_WIDTH   = 5,
  parameter int LINES_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [LINES_WIDTH-1:0] num_lines,
  output logic                   busy,
  output logic                   done,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   in_ready,
  output logic                   flag_wr_req,
  output logic                   flag_wr_data,
  output logic                   nz_valid,
  output logic [DATA_WIDTH-1:0]  nz_data,
  output logic [IDX_WIDTH-1:0]   nz_index,
  input  logic                   nz_ready,
  output logic                   line_valid,
  output logic [CNT_WIDTH-1:0]   line_nnz
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                 state, state_next;
  logic [LINES_WIDTH-1:0] num_lines_q;
  logic [LINES_WIDTH-1:0] line_cnt;
  logic [IDX_WIDTH-1:0]   elem_cnt;
  logic [CNT_WIDTH-1:0]   nnz_cnt;
  logic                   accept;
  logic                   elem_nz;
  logic                   last_elem;
  logic                   last_line;
  logic                   done_next;
  logic                   latch_cmd;

  // A stalled nz register blocks intake so no nonzero element is ever dropped.
  assign in_ready  = (state == RUN) && (!nz_valid || nz_ready);
  assign accept    = in_valid && in_ready;
  assign elem_nz   = (in_data != '0);
  assign last_elem = (elem_cnt == IDX_WIDTH'(LINE_LEN - 1));
  assign last_line = ((line_cnt + LINES_WIDTH'(1)) == num_lines_q);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    latch_cmd  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          latch_cmd = 1'b1;
          if (num_lines == '0) done_next = 1'b1;
          else                 state_next = RUN;
        end
      end
      RUN: begin
        if (accept && last_elem && last_line) state_next = DRAIN;
      end
      DRAIN: begin
        if (!nz_valid || nz_ready) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      num_lines_q  <= '0;
      line_cnt     <= '0;
      elem_cnt     <= '0;
      nnz_cnt      <= '0;
      flag_wr_req  <= 1'b0;
      flag_wr_data <= 1'b0;
      nz_valid     <= 1'b0;
      nz_data      <= '0;
      nz_index     <= '0;
      line_valid   <= 1'b0;
      line_nnz     <= '0;
    end else begin
      flag_wr_req  <= accept;
      flag_wr_data <= accept && elem_nz;
      line_valid   <= accept && last_elem;

      // Reload on a new nonzero even while the old one is being taken: no bubble.
      if (accept && elem_nz) begin
        nz_valid <= 1'b1;
        nz_data  <= in_data;
        nz_index <= elem_cnt;
      end else if (nz_ready) begin
        nz_valid <= 1'b0;
      end

      if (latch_cmd) begin
        num_lines_q <= num_lines;
        line_cnt    <= '0;
        elem_cnt    <= '0;
        nnz_cnt     <= '0;
      end else if (accept) begin
        if (last_elem) begin
          line_nnz <= nnz_cnt + CNT_WIDTH'(elem_nz);
          elem_cnt <= '0;
          nnz_cnt  <= '0;
          line_cnt <= line_cnt + LINES_WIDTH'(1);
        end else begin
          elem_cnt <= elem_cnt + IDX_WIDTH'(1);
          nnz_cnt  <= nnz_cnt + CNT_WIDTH'(elem_nz);
        end
      end
    end
  end

endmodule

// File: tb/tb_sparsity_encoder.sv
// Self-checking bench for sparsity_encoder: a queue-based model predicts flags,
// compressed elements and line counts from the dense data each command sends.
module tb_sparsity_encoder;

  localparam int DATA_WIDTH  = 8;
  localparam int LINE_LEN    = 16;
  localparam int IDX_WIDTH   = 4;
  localparam int CNT_WIDTH   = 5;
  localparam int LINES_WIDTH = 8;

  typedef struct {
    int num_lines;
    int mode;
    int rmode;
    int gaps;
    int restart;
    int exp_flags;
  } vec_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic [LINES_WIDTH-1:0] num_lines;
  logic                   busy;
  logic                   done;
  logic                   in_valid;
  logic [DATA_WIDTH-1:0]  in_data;
  logic                   in_ready;
  logic                   flag_wr_req;
  logic                   flag_wr_data;
  logic                   nz_valid;
  logic [DATA_WIDTH-1:0]  nz_data;
  logic [IDX_WIDTH-1:0]   nz_index;
  logic                   nz_ready;
  logic                   line_valid;
  logic [CNT_WIDTH-1:0]   line_nnz;

  int n_checks = 0;
  int n_fail   = 0;
  int flag_seen = 0;
  int done_seen = 0;
  int stall_seen = 0;
  int ready_mode = 0;
  int stall_left = 0;
  bit stall_armed = 0;
  bit prev_stall = 0;
  int prev_data = 0;
  int prev_idx = 0;

  int exp_flags[$];
  int exp_nz_d[$];
  int exp_nz_i[$];
  int exp_lines[$];

  vec_t vecs[8];

  sparsity_encoder #(
    .DATA_WIDTH(DATA_WIDTH), .LINE_LEN(LINE_LEN), .IDX_WIDTH(IDX_WIDTH),
    .CNT_WIDTH(CNT_WIDTH), .LINES_WIDTH(LINES_WIDTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_lines(num_lines),
    .busy(busy), .done(done), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .flag_wr_req(flag_wr_req), .flag_wr_data(flag_wr_data),
    .nz_valid(nz_valid), .nz_data(nz_data), .nz_index(nz_index),
    .nz_ready(nz_ready), .line_valid(line_valid), .line_nnz(line_nnz)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Downstream ready generator: always ready, random, or one 5-cycle stall.
  always begin
    @(posedge clk);
    #1;
    case (ready_mode)
      1: nz_ready = ($urandom_range(0, 9) < 7);
      2: begin
        if (stall_left > 0) begin
          nz_ready = 1'b0;
          stall_left--;
        end else if (stall_armed && nz_valid) begin
          nz_ready = 1'b0;
          stall_left = 4;
          stall_armed = 0;
        end else begin
          nz_ready = 1'b1;
        end
      end
      default: nz_ready = 1'b1;
    endcase
  end

  // Monitor: compares every output event against the model queues.
  always @(negedge clk) begin
    if (flag_wr_req === 1'b1) begin
      flag_seen++;
      if (exp_flags.size() == 0) checkOutput("flag_unexpected", 1, 0);
      else checkOutput("flag_bit", int'(flag_wr_data), exp_flags.pop_front());
    end
    if (prev_stall) begin
      checkOutput("nz_hold_valid", int'(nz_valid), 1);
      checkOutput("nz_hold_data", int'(nz_data), prev_data);
      checkOutput("nz_hold_index", int'(nz_index), prev_idx);
    end
    if (nz_valid === 1'b1 && nz_ready === 1'b1) begin
      if (exp_nz_d.size() == 0) checkOutput("nz_unexpected", 1, 0);
      else begin
        checkOutput("nz_data", int'(nz_data), exp_nz_d.pop_front());
        checkOutput("nz_index", int'(nz_index), exp_nz_i.pop_front());
      end
    end
    if (nz_valid === 1'b1 && nz_ready === 1'b0) begin
      stall_seen++;
      checkOutput("in_ready_stall", int'(in_ready), 0);
    end
    if (busy === 1'b0) checkOutput("in_ready_idle", int'(in_ready), 0);
    prev_stall = (nz_valid === 1'b1) && (nz_ready === 1'b0) && (reset === 1'b0);
    prev_data  = int'(nz_data);
    prev_idx   = int'(nz_index);
    if (line_valid === 1'b1) begin
      if (exp_lines.size() == 0) checkOutput("line_unexpected", 1, 0);
      else checkOutput("line_nnz", int'(line_nnz), exp_lines.pop_front());
    end
    if (done === 1'b1) begin
      done_seen++;
      checkOutput("done_flags_pending", exp_flags.size(), 0);
      checkOutput("done_lines_pending", exp_lines.size(), 0);
      checkOutput("done_nz_pending", exp_nz_d.size(), 0);
      checkOutput("done_nz_valid", int'(nz_valid), 0);
    end
  end

  function automatic int genData(input int mode, input int l, input int e);
    case (mode)
      0: return (e == 1) ? 5 : (e == 4) ? 7 : 0;
      1: return (l == 0) ? 0 : 255;
      2: return $urandom_range(1, 255);
      default: return ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 255);
    endcase
  endfunction

  // Model: one flag per element, nonzeros with their position, count per line.
  task automatic modelLine(input int data[LINE_LEN], input int count_line);
    int nnz = 0;
    for (int e = 0; e < LINE_LEN; e++) begin
      exp_flags.push_back(data[e] != 0);
      if (data[e] != 0) begin
        exp_nz_d.push_back(data[e]);
        exp_nz_i.push_back(e);
        nnz++;
      end
    end
    if (count_line != 0) exp_lines.push_back(nnz);
  endtask

  task automatic feedElement(input int data, input int gaps, input int restart_now);
    bit acc;
    if (gaps != 0 && $urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      in_data  = DATA_WIDTH'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = DATA_WIDTH'(data);
    if (restart_now != 0) begin
      start     = 1'b1;
      num_lines = LINES_WIDTH'(5);
    end
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (acc) return;
    end
    $display("[TB] FAIL accept_timeout: got no accept, expected accept within 200 cycles");
    $fatal(1, "[TB] aborting");
  endtask

  task automatic pulseStart(input int lines);
    @(posedge clk);
    #1;
    start = 1'b1;
    num_lines = LINES_WIDTH'(lines);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    int stream[$];
    int line_data[LINE_LEN];
    int done_base;
    flag_seen = 0;
    stall_seen = 0;
    done_base = done_seen;
    ready_mode = v.rmode;
    stall_armed = (v.rmode == 2);
    for (int l = 0; l < v.num_lines; l++) begin
      for (int e = 0; e < LINE_LEN; e++) begin
        line_data[e] = genData(v.mode, l, e);
        stream.push_back(line_data[e]);
      end
      modelLine(line_data, 1);
    end
    pulseStart(v.num_lines);
    if (v.num_lines == 0) begin
      @(negedge clk);
      checkOutput("done_zero_lines", int'(done), 1);
      checkOutput("busy_zero_lines", int'(busy), 0);
      @(negedge clk);
      checkOutput("done_single_pulse", int'(done), 0);
    end
    for (int k = 0; k < stream.size(); k++)
      feedElement(stream[k], v.gaps, (v.restart != 0 && k == 20) ? 1 : 0);
    in_valid = 1'b0;
    for (int c = 0; c < 200 && done_seen == done_base; c++) @(posedge clk);
    checkOutput("done_count", done_seen - done_base, 1);
    @(negedge clk);
    checkOutput("busy_after_done", int'(busy), 0);
    checkOutput("done_after_pulse", int'(done), 0);
    checkOutput("flag_total", flag_seen, v.exp_flags);
    checkOutput("queues_empty", exp_flags.size() + exp_nz_d.size() + exp_lines.size(), 0);
    if (v.rmode == 2) checkOutput("stall_cycles", stall_seen, 5);
    ready_mode = 0;
  endtask

  task automatic resetMidLine();
    int line_data[LINE_LEN];
    int done_base;
    for (int e = 0; e < LINE_LEN; e++) line_data[e] = (e % 3 == 0) ? 0 : e + 1;
    for (int e = 0; e < 7; e++) begin
      exp_flags.push_back(line_data[e] != 0);
      if (line_data[e] != 0) begin
        exp_nz_d.push_back(line_data[e]);
        exp_nz_i.push_back(e);
      end
    end
    ready_mode = 0;
    pulseStart(1);
    for (int e = 0; e < 7; e++) feedElement(line_data[e], 0, 0);
    in_valid = 1'b0;
    reset = 1'b1;
    done_base = done_seen;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_mid_outputs",
      int'({flag_wr_req, flag_wr_data, nz_valid, nz_data, nz_index, line_valid, line_nnz, done, busy, in_ready}), 0);
    checkOutput("reset_mid_pending", exp_flags.size() + exp_nz_d.size(), 0);
    repeat (5) @(posedge clk);
    checkOutput("reset_mid_no_done", done_seen - done_base, 0);
  endtask

  initial begin
    vecs[0] = '{1, 0, 0, 0, 0, 16};
    vecs[1] = '{2, 1, 0, 0, 0, 32};
    vecs[2] = '{1, 2, 2, 0, 0, 16};
    vecs[3] = '{0, 3, 0, 0, 0, 0};
    vecs[4] = '{2, 3, 0, 0, 1, 32};
    vecs[5] = '{3, 3, 1, 1, 0, 48};
    vecs[6] = '{4, 2, 1, 1, 0, 64};
    vecs[7] = '{1, 3, 1, 0, 0, 16};

    reset = 1'b1;
    start = 1'b0;
    num_lines = '0;
    in_valid = 1'b0;
    in_data = '0;
    nz_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_outputs",
      int'({flag_wr_req, flag_wr_data, nz_valid, nz_data, nz_index, line_valid, line_nnz, done, busy, in_ready}), 0);

    flag_seen = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data = 8'h33;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("idle_no_flags", flag_seen, 0);

    resetMidLine();

    for (int i = 0; i < 8; i++) begin
      $display("[TB] vector %0d: num_lines=%0d mode=%0d rmode=%0d", i, vecs[i].num_lines, vecs[i].mode, vecs[i].rmode);
      applyStimulus(vecs[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
